// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the multicycle RV32I controller: state encoding, opcode
// constants, immediate-format select codes and the ID-stage dispatch helper.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_LD    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EX_R     = 4'd6,
    S_EX_I     = 4'd7,
    S_WB_ALU   = 4'd8,
    S_EX_BR    = 4'd9,
    S_EX_JAL   = 4'd10,
    S_EX_JALR  = 4'd11,
    S_WB_LINK  = 4'd12,
    S_EX_U     = 4'd13,
    S_WB_U     = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] CC_NONE  = 3'b000;
  localparam logic [2:0] CC_U     = 3'b001;
  localparam logic [2:0] CC_J     = 3'b010;
  localparam logic [2:0] CC_I     = 3'b011;
  localparam logic [2:0] CC_B     = 3'b100;
  localparam logic [2:0] CC_S     = 3'b101;
  localparam logic [2:0] CC_SHAMT = 3'b110;

  // Dispatch from ID; f3_ok only matters for memory opcodes.
  function automatic state_t id_next(input logic [6:0] op, input logic f3_ok);
    state_t nxt;
    case (op)
      OPC_LOAD,
      OPC_STORE:  nxt = f3_ok ? S_MEM_ADDR : S_TRAP;
      OPC_OP:     nxt = S_EX_R;
      OPC_OP_IMM: nxt = S_EX_I;
      OPC_BRANCH: nxt = S_EX_BR;
      OPC_JAL:    nxt = S_EX_JAL;
      OPC_JALR:   nxt = S_EX_JALR;
      OPC_LUI,
      OPC_AUIPC:  nxt = S_EX_U;
      default:    nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake bundle between the controller (master) and the
// instruction/data memory side (slave).
interface multicycle_ctrl_fsm_if #(
  parameter int BE_W = 4
) ();
  logic            imem_ready;
  logic            dmem_ready;
  logic            MemRead;
  logic            MemWrite;
  logic [BE_W-1:0] BE;

  modport master (
    input  imem_ready, dmem_ready,
    output MemRead, MemWrite, BE
  );

  modport slave (
    output imem_ready, dmem_ready,
    input  MemRead, MemWrite, BE
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_be_decode.sv
// funct3 -> 4-bit byte-enable and load/store funct3 legality.
module mcc_be_decode
  import mcc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_store,
  output logic [3:0] be,
  output logic       legal
);

  always_comb begin
    be    = 4'b0000;
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b100: be = 4'b0001;
      3'b001, 3'b101: be = 4'b0011;
      3'b010:         be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
    if (is_store) legal = (funct3 <= 3'b010);
    else          legal = !(funct3 inside {3'b011, 3'b110, 3'b111});
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM with memory wait states, latched decode and
// illegal-instruction trap. Optional counters: define MCC_PERF_COUNT_EN.
module multicycle_ctrl_fsm
  import mcc_pkg::*;
#(
  parameter int ALUOP_W = 7,
  parameter int BE_W    = 4,
  parameter int CNT_W   = 32
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  multicycle_ctrl_fsm_if.master  mbus,
  output logic                   RegDst,
  output logic                   Jump,
  output logic                   Branch,
  output logic                   MemtoReg,
  output logic                   ALUSrc1,
  output logic                   ALUSrc2,
  output logic                   RegWrite,
  output logic                   JALorJALR,
  output logic [ALUOP_W-1:0]     ALUOp,
  output logic [2:0]             Concat_control,
  output logic                   PCWrite,
  output logic                   IRWrite,
  output logic                   instr_done,
  output logic                   illegal_instr,
  output logic [3:0]             state_o
`ifdef MCC_PERF_COUNT_EN
  ,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       instret_cnt
`endif
);

  if (!(BE_W == 4 || BE_W == 8) || CNT_W < 1) begin : g_param_check
    $error("multicycle_ctrl_fsm: BE_W must be 4 or 8 and CNT_W positive");
  end

  state_t     state_q, state_d;
  logic [6:0] lop_q;
  logic [2:0] lf3_q;
  logic       illegal_q;

  logic [2:0]         dec_f3;
  logic               dec_store;
  logic [3:0]         dec_be;
  logic               dec_legal;
  logic               mem_read_c, mem_write_c, be_en_c;
  logic [ALUOP_W-1:0] aluop_lat;

  // One decoder serves both ID (live IR) and the MEM states (latched funct3).
  always_comb begin
    dec_f3    = lf3_q;
    dec_store = (lop_q == OPC_STORE);
    if (state_q == S_ID) begin
      dec_f3    = funct3;
      dec_store = (opcode == OPC_STORE);
    end
  end

  mcc_be_decode u_be_decode (
    .funct3   (dec_f3),
    .is_store (dec_store),
    .be       (dec_be),
    .legal    (dec_legal)
  );

  assign aluop_lat = ALUOP_W'(lop_q);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IF;
      lop_q     <= 7'd0;
      lf3_q     <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        lop_q <= opcode;
        lf3_q <= funct3;
      end
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:       if (mbus.imem_ready) state_d = S_ID;
      S_ID:       state_d = id_next(opcode, dec_legal);
      S_MEM_ADDR: state_d = (lop_q == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mbus.dmem_ready) state_d = S_WB_LD;
      S_MEM_WR:   if (mbus.dmem_ready) state_d = S_IF;
      S_EX_R,
      S_EX_I:     state_d = S_WB_ALU;
      S_EX_JAL,
      S_EX_JALR:  state_d = S_WB_LINK;
      S_EX_U:     state_d = S_WB_U;
      S_WB_LD,
      S_WB_ALU,
      S_WB_LINK,
      S_WB_U,
      S_EX_BR:    state_d = S_IF;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IF;
    endcase
  end

  // Moore decode; IF's fetch strobes are also qualified by RSTn so a held
  // reset shows only MemRead even with imem_ready high.
  always_comb begin
    RegDst         = 1'b0;
    Jump           = 1'b0;
    Branch         = 1'b0;
    MemtoReg       = 1'b0;
    ALUSrc1        = 1'b0;
    ALUSrc2        = 1'b0;
    RegWrite       = 1'b0;
    JALorJALR      = 1'b0;
    ALUOp          = '0;
    Concat_control = CC_NONE;
    PCWrite        = 1'b0;
    IRWrite        = 1'b0;
    instr_done     = 1'b0;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    be_en_c        = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read_c = 1'b1;
        if (mbus.imem_ready && RSTn) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        ALUSrc2        = 1'b1;
        Concat_control = (lop_q == OPC_STORE) ? CC_S : CC_I;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        be_en_c    = 1'b1;
      end
      S_WB_LD: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        be_en_c     = 1'b1;
        instr_done  = mbus.dmem_ready;
      end
      S_EX_R: begin
        ALUOp          = aluop_lat;
        Concat_control = CC_NONE;
      end
      S_EX_I: begin
        ALUSrc2        = 1'b1;
        ALUOp          = aluop_lat;
        Concat_control = (lf3_q == 3'b001 || lf3_q == 3'b101) ? CC_SHAMT : CC_I;
      end
      S_WB_ALU, S_WB_LINK, S_WB_U: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EX_BR: begin
        Branch         = 1'b1;
        ALUOp          = aluop_lat;
        Concat_control = CC_B;
        PCWrite        = 1'b1;
        instr_done     = 1'b1;
      end
      S_EX_JAL: begin
        Jump           = 1'b1;
        ALUSrc1        = 1'b1;
        ALUSrc2        = 1'b1;
        Concat_control = CC_J;
        PCWrite        = 1'b1;
      end
      S_EX_JALR: begin
        Jump           = 1'b1;
        JALorJALR      = 1'b1;
        ALUSrc2        = 1'b1;
        Concat_control = CC_I;
        PCWrite        = 1'b1;
      end
      S_EX_U: begin
        ALUSrc1        = (lop_q == OPC_AUIPC);
        ALUSrc2        = 1'b1;
        Concat_control = CC_U;
        ALUOp          = aluop_lat;
      end
      default: ;
    endcase
  end

  assign mbus.MemRead  = mem_read_c;
  assign mbus.MemWrite = mem_write_c;
  assign mbus.BE       = be_en_c ? BE_W'(dec_be) : '0;
  assign illegal_instr = illegal_q;
  assign state_o       = state_q;

`ifdef MCC_PERF_COUNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done)        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed + randomized bench: a per-instruction cycle schedule of expected
// controls is built from the instruction class, then replayed on the DUT.
module tb_multicycle_ctrl_fsm;
  import mcc_pkg::*;

  typedef struct packed {
    logic       reg_dst, jump, branch, mem_read, memto_reg, mem_write;
    logic       alu_src1, alu_src2, reg_write, jal_or_jalr;
    logic [6:0] alu_op;
    logic [3:0] be;
    logic [2:0] concat;
    logic       pc_write, ir_write, instr_done, illegal;
  } ctl_t;

  typedef struct {
    logic       imem, dmem;
    logic [6:0] op;
    logic [2:0] f3;
    ctl_t       exp;
    string      tag;
  } step_t;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       RegDst, Jump, Branch, MemtoReg, ALUSrc1, ALUSrc2, RegWrite, JALorJALR;
  logic [6:0] ALUOp;
  logic [2:0] Concat_control;
  logic       PCWrite, IRWrite, instr_done, illegal_instr;
  logic [3:0] state_o;
`ifdef MCC_PERF_COUNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl_fsm_if #(.BE_W(4)) mem_bus ();

  multicycle_ctrl_fsm #(.ALUOP_W(7), .BE_W(4), .CNT_W(32)) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .opcode         (opcode),
    .funct3         (funct3),
    .mbus           (mem_bus.master),
    .RegDst         (RegDst),
    .Jump           (Jump),
    .Branch         (Branch),
    .MemtoReg       (MemtoReg),
    .ALUSrc1        (ALUSrc1),
    .ALUSrc2        (ALUSrc2),
    .RegWrite       (RegWrite),
    .JALorJALR      (JALorJALR),
    .ALUOp          (ALUOp),
    .Concat_control (Concat_control),
    .PCWrite        (PCWrite),
    .IRWrite        (IRWrite),
    .instr_done     (instr_done),
    .illegal_instr  (illegal_instr),
    .state_o        (state_o)
`ifdef MCC_PERF_COUNT_EN
    ,
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int     vectors = 0;
  int     miscompares = 0;
  int     exp_instret = 0;
  step_t  sq[$];

  function automatic ctl_t observed();
    ctl_t o;
    o = '{reg_dst: RegDst, jump: Jump, branch: Branch, mem_read: mem_bus.MemRead,
          memto_reg: MemtoReg, mem_write: mem_bus.MemWrite, alu_src1: ALUSrc1,
          alu_src2: ALUSrc2, reg_write: RegWrite, jal_or_jalr: JALorJALR,
          alu_op: ALUOp, be: mem_bus.BE, concat: Concat_control, pc_write: PCWrite,
          ir_write: IRWrite, instr_done: instr_done, illegal: illegal_instr};
    return o;
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = observed();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    vectors++;
    assert (state_o === 4'(exp)) else begin
      miscompares++;
      $error("FAIL %s: observed state %0d expected %0d", tag, state_o, exp);
    end
  endtask

  function automatic ctl_t reset_vec();
    ctl_t e;
    e = '0;
    e.mem_read = 1'b1;
    return e;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 4'b0001;
      3'd1, 3'd5: return 4'b0011;
      3'd2:       return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == OPC_LOAD)  return !(f3 inside {3'd3, 3'd6, 3'd7});
    if (op == OPC_STORE) return f3 <= 3'd2;
    return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_OP_IMM, OPC_OP};
  endfunction

  // Inputs not under test on a cycle are randomized: readies outside their
  // wait state and the IR outside ID must have no effect.
  task automatic push(input int imem, input int dmem, input logic [6:0] op,
                      input logic [2:0] f3, input ctl_t e, input string tag);
    step_t s;
    s.imem = (imem < 0) ? 1'($urandom_range(0, 1)) : 1'(imem);
    s.dmem = (dmem < 0) ? 1'($urandom_range(0, 1)) : 1'(dmem);
    s.op   = op;
    s.f3   = f3;
    s.exp  = e;
    s.tag  = tag;
    sq.push_back(s);
  endtask

  task automatic push_g(input int imem, input int dmem, input ctl_t e, input string tag);
    push(imem, dmem, 7'($urandom), 3'($urandom), e, tag);
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input int iw,
                       input int dw, input int trap_cycles);
    ctl_t e;
    for (int i = 0; i < iw; i++) begin
      e = '0; e.mem_read = 1'b1;
      push_g(0, -1, e, "if_wait");
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push_g(1, -1, e, "if_fetch");
    e = '0;
    push(-1, -1, op, f3, e, "id");
    if (!legal(op, f3)) begin
      for (int i = 0; i < trap_cycles; i++) begin
        e = '0; e.illegal = 1'b1;
        push_g(-1, -1, e, "trap");
      end
      return;
    end
    case (op)
      OPC_LOAD, OPC_STORE: begin
        e = '0; e.alu_src2 = 1'b1; e.concat = (op == OPC_STORE) ? CC_S : CC_I;
        push_g(-1, -1, e, "mem_addr");
        e = '0; e.be = be_of(f3);
        if (op == OPC_LOAD) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        for (int i = 0; i < dw; i++) push_g(-1, 0, e, "mem_wait");
        if (op == OPC_STORE) e.instr_done = 1'b1;
        push_g(-1, 1, e, "mem_done");
        if (op == OPC_LOAD) begin
          e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; e.memto_reg = 1'b1; e.instr_done = 1'b1;
          push_g(-1, -1, e, "wb_ld");
        end
      end
      OPC_OP, OPC_OP_IMM: begin
        e = '0; e.alu_op = op;
        if (op == OPC_OP_IMM) begin
          e.alu_src2 = 1'b1;
          e.concat   = (f3 == 3'd1 || f3 == 3'd5) ? CC_SHAMT : CC_I;
        end
        push_g(-1, -1, e, "ex_alu");
        e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        push_g(-1, -1, e, "wb_alu");
      end
      OPC_BRANCH: begin
        e = '0; e.branch = 1'b1; e.alu_op = op; e.concat = CC_B;
        e.pc_write = 1'b1; e.instr_done = 1'b1;
        push_g(-1, -1, e, "ex_br");
      end
      default: begin
        e = '0; e.alu_src2 = 1'b1;
        if (op == OPC_JAL) begin
          e.jump = 1'b1; e.alu_src1 = 1'b1; e.concat = CC_J; e.pc_write = 1'b1;
        end else if (op == OPC_JALR) begin
          e.jump = 1'b1; e.jal_or_jalr = 1'b1; e.concat = CC_I; e.pc_write = 1'b1;
        end else begin
          e.alu_src1 = (op == OPC_AUIPC); e.concat = CC_U; e.alu_op = op;
        end
        push_g(-1, -1, e, "ex_jump_u");
        e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        push_g(-1, -1, e, "wb_link_u");
      end
    endcase
  endtask

  task automatic apply_one();
    step_t s;
    s = sq.pop_front();
    @(negedge CLK);
    mem_bus.imem_ready = s.imem;
    mem_bus.dmem_ready = s.dmem;
    opcode = s.op;
    funct3 = s.f3;
    #1;
    chk_ctl(s.tag, s.exp);
    if (s.exp.instr_done) exp_instret++;
  endtask

  task automatic run_all();
    while (sq.size() > 0) apply_one();
  endtask

  task automatic do_reset(input logic imem_hi);
    @(negedge CLK);
    RSTn = 1'b0;
    mem_bus.imem_ready = imem_hi;
    mem_bus.dmem_ready = 1'b1;
    opcode = OPC_OP;
    #1;
    chk_ctl("reset", reset_vec());
    chk_state("reset_state", S_IF);
    @(negedge CLK);
    #1;
    chk_ctl("reset_hold", reset_vec());
    mem_bus.imem_ready = 1'b0;
    #1;
    RSTn = 1'b1;
    exp_instret = 0;
  endtask

  task automatic rand_instr();
    logic [6:0] ops [9];
    logic [2:0] ld_f3 [5];
    logic [6:0] op;
    logic [2:0] f3;
    ops   = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
              OPC_STORE, OPC_OP_IMM, OPC_OP};
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    op = ops[$urandom_range(0, 8)];
    f3 = 3'($urandom);
    if (op == OPC_LOAD)  f3 = ld_f3[$urandom_range(0, 4)];
    if (op == OPC_STORE) f3 = 3'($urandom_range(0, 2));
    build(op, f3, $urandom_range(0, 3), $urandom_range(0, 3), 0);
  endtask

  initial begin
    mem_bus.imem_ready = 1'b0;
    mem_bus.dmem_ready = 1'b0;

    // Reset with an R-type in the IR and imem_ready high, then one R-type.
    do_reset(1'b1);
    build(OPC_OP, 3'd0, 0, 0, 0);
    run_all();

    // LW with three data wait cycles.
    build(OPC_LOAD, 3'd2, 0, 3, 0);
    run_all();

    // SH, no waits.
    build(OPC_STORE, 3'd1, 0, 0, 0);
    run_all();

    // SRAI with the IR switched to a load opcode during EX_I.
    build(OPC_OP_IMM, 3'd5, 0, 0, 0);
    sq[2].op = OPC_LOAD;
    run_all();

    // One of each remaining class, with fetch waits.
    build(OPC_BRANCH, 3'd1, 2, 0, 0); run_all();
    build(OPC_JAL,    3'd0, 1, 0, 0); run_all();
    build(OPC_JALR,   3'd0, 0, 0, 0); run_all();
    build(OPC_LUI,    3'd3, 0, 0, 0); run_all();
    build(OPC_AUIPC,  3'd7, 0, 0, 0); run_all();
    build(OPC_LOAD,   3'd4, 1, 2, 0); run_all();
    build(OPC_STORE,  3'd0, 0, 4, 0); run_all();

    for (int n = 0; n < 80; n++) begin
      rand_instr();
      run_all();
    end

`ifdef MCC_PERF_COUNT_EN
    vectors++;
    assert (instret_cnt === 32'(exp_instret)) else begin
      miscompares++;
      $error("FAIL instret_cnt: observed %0d expected %0d", instret_cnt, exp_instret);
    end
`endif

    // Unknown opcode: trap held for 100 cycles, cleared by reset.
    build(7'b1111111, 3'd0, 1, 0, 100);
    run_all();
    chk_state("trap_state", S_TRAP);
    do_reset(1'b0);

    // Load with funct3=111 traps too.
    build(OPC_LOAD, 3'd7, 0, 0, 5);
    run_all();
    chk_state("trap_ld_state", S_TRAP);
    do_reset(1'b0);

    // Asynchronous reset asserted between edges while in EX_JAL.
    build(OPC_JAL, 3'd0, 0, 0, 0);
    apply_one();
    apply_one();
    apply_one();
    sq.delete();
    #1;
    RSTn = 1'b0;
    #1;
    chk_ctl("async_rst", reset_vec());
    chk_state("async_rst_state", S_IF);
    @(negedge CLK);
    mem_bus.imem_ready = 1'b0;
    #1;
    RSTn = 1'b1;

    // Recovery after the asynchronous reset.
    build(OPC_OP_IMM, 3'd0, 0, 0, 0);
    run_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
